// File: rtl/multichannel_delayline_pkg.sv
// Shared types for the multichannel delay line: sample type, FSM states, and the sum clamp.
// The clamp is written on 32-bit values so that it serves any sample width up to 31 bits.
package delayline_pkg;

   localparam int DEF_W = 16;

   typedef logic signed [DEF_W-1:0] sample_t;

   typedef enum logic [2:0] {CLEAR, IDLE, RD, WR, DONE} dl_state_t;

   // Clamps x to the signed range of a w-bit sample.
   function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/multichannel_delayline_if.sv
// Strobe, sample and status bundle between the sample-rate source/DSP side and the delay line.
// master drives strobe, delay, fb_gain and in; slave returns out, out_valid and busy.
interface multichannel_delayline_if #(
   parameter int W    = 16,
   parameter int N_CH = 4,
   parameter int AW   = 10,
   parameter int FBW  = 8
);
   logic                strobe;
   logic [N_CH*AW-1:0]  delay;
   logic [N_CH*FBW-1:0] fb_gain;
   logic [N_CH*W-1:0]   in;
   logic [N_CH*W-1:0]   out;
   logic                out_valid;
   logic                busy;

   modport master (output strobe, delay, fb_gain, in, input out, out_valid, busy);
   modport slave  (input strobe, delay, fb_gain, in, output out, out_valid, busy);
endinterface

// File: rtl/multichannel_delayline_ram.sv
// Simple dual-port RAM: one write port, one read port with a single-cycle registered read.
// There is no reset, so the array maps onto block RAM; the owner clears the contents itself.
module sdp_ram #(
   parameter int DW = 16,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q
);
   logic [DW-1:0] mem [1<<AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
   end
endmodule

// File: rtl/multichannel_delayline.sv
// N-channel delay/echo line that services one channel at a time from a shared RAM; out_valid follows an accepted strobe by 2*N_CH+1 cycles.
// Backpressure: busy is high during the RAM clear and the servicing pass, and strobes that arrive while busy is high are dropped.
module multichannel_delayline
   import delayline_pkg::*;
#(
   parameter int W         = 16,
   parameter int MAX_DELAY = 1024,
   parameter int N_CH      = 4,
   parameter int FBW       = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multichannel_delayline_if.slave  dl
);
   localparam int AW  = $clog2(MAX_DELAY);
   localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RAW = CW + AW;

   dl_state_t          state_q, state_d;
   logic [CW-1:0]      ch_q;
   logic [AW-1:0]      wptr_q;
   logic [AW-1:0]      cur_delay_q [N_CH];
   logic [RAW-1:0]     clr_addr_q;
   logic [N_CH*W-1:0]  in_q, out_q;
   logic [N_CH*AW-1:0] delay_q;
   logic [N_CH*FBW-1:0] fb_q;

   logic                 last_ch;
   logic [AW-1:0]        cur_ch, tgt_ch;
   logic signed [W-1:0]  rd_s, in_ch;
   logic [FBW-1:0]       fb_ch;
   logic signed [W+FBW:0] prod;
   logic signed [W:0]    sum;
   logic [W-1:0]         ram_q, wdata;
   logic                 ram_we;
   logic [RAW-1:0]       ram_waddr, ram_raddr;
   logic [W-1:0]         ram_wdata;

   assign last_ch = (ch_q == CW'(N_CH - 1));
   assign cur_ch  = cur_delay_q[ch_q];
   assign tgt_ch  = (delay_q[ch_q*AW +: AW] == '0) ? AW'(1) : delay_q[ch_q*AW +: AW];
   assign rd_s    = $signed(ram_q);
   assign in_ch   = $signed(in_q[ch_q*W +: W]);
   assign fb_ch   = fb_q[ch_q*FBW +: FBW];

   // Gain is unsigned Q0.FBW, so a zero sign bit is prepended before the signed multiply.
   assign prod  = (W+FBW+1)'(rd_s) * (W+FBW+1)'($signed({1'b0, fb_ch}));
   assign sum   = $signed({in_ch[W-1], in_ch}) + (W+1)'(prod >>> FBW);
   assign wdata = W'(sat_w(32'(sum), W));

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = {ch_q, wptr_q};
      ram_wdata = wdata;
      ram_raddr = {ch_q, AW'(wptr_q - cur_ch)};
      if (state_q == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr_q;
         ram_wdata = '0;
      end else if (state_q == WR) begin
         ram_we = 1'b1;
      end
   end

   sdp_ram #(.DW(W), .AW(RAW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .q     (ram_q)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clr_addr_q == '1) state_d = IDLE;
         IDLE:    if (dl.strobe) state_d = RD;
         RD:      state_d = WR;
         WR:      state_d = last_ch ? DONE : RD;
         DONE:    state_d = IDLE;
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= CLEAR;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_addr_q <= '0;
         ch_q       <= '0;
         wptr_q     <= '0;
         in_q       <= '0;
         out_q      <= '0;
         delay_q    <= '0;
         fb_q       <= '0;
         for (int c = 0; c < N_CH; c++) cur_delay_q[c] <= AW'(1);
      end else begin
         case (state_q)
            CLEAR: clr_addr_q <= clr_addr_q + RAW'(1);
            IDLE: if (dl.strobe) begin
               in_q    <= dl.in;
               delay_q <= dl.delay;
               fb_q    <= dl.fb_gain;
               ch_q    <= '0;
            end
            WR: begin
               out_q[ch_q*W +: W] <= ram_q;
               // Slew one sample per strobe toward the target so delay changes do not click.
               if (tgt_ch > cur_ch)      cur_delay_q[ch_q] <= cur_ch + AW'(1);
               else if (tgt_ch < cur_ch) cur_delay_q[ch_q] <= cur_ch - AW'(1);
               if (!last_ch) ch_q <= ch_q + CW'(1);
            end
            DONE: wptr_q <= wptr_q + AW'(1);
            default: ;
         endcase
      end
   end

   assign dl.out       = out_q;
   assign dl.out_valid = (state_q == DONE);
   assign dl.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_multichannel_delayline.sv
// Bench for multichannel_delayline: a reference model pushes expected outputs per strobe and each out_valid pops one.
// Scenario tasks add hand-derived constant checks for reset, delay, slew, echo, saturation and timing.
module tb_multichannel_delayline;
   localparam int W = 16, N_CH = 4, MAX_DELAY = 1024, AW = 10, FBW = 8;
   localparam int LAT = 2*N_CH + 1;
   localparam int CLR_CYCLES = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multichannel_delayline_if #(.W(W), .N_CH(N_CH), .AW(AW), .FBW(FBW)) dl ();

   multichannel_delayline #(.W(W), .MAX_DELAY(MAX_DELAY), .N_CH(N_CH), .FBW(FBW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dl    (dl)
   );

   int checks = 0;
   int errors = 0;
   int cur_in [N_CH];
   int cur_dly[N_CH];
   int cur_fb [N_CH];
   int got    [N_CH];
   int mem    [N_CH][MAX_DELAY];
   int m_cur  [N_CH];
   int m_wptr;
   logic [N_CH*W-1:0] exp_q[$];

   function automatic void model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_cur[c] = 1;
         for (int a = 0; a < MAX_DELAY; a++) mem[c][a] = 0;
      end
      m_wptr = 0;
      exp_q.delete();
   endfunction

   function automatic logic [N_CH*W-1:0] model_step();
      logic [N_CH*W-1:0] e;
      int rd, s, tgt;
      e = '0;
      for (int c = 0; c < N_CH; c++) begin
         rd = mem[c][(m_wptr - m_cur[c]) & (MAX_DELAY-1)];
         e[c*W +: W] = rd[W-1:0];
         s = cur_in[c] + ((rd * cur_fb[c]) >>> FBW);
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         mem[c][m_wptr] = s;
         tgt = (cur_dly[c] == 0) ? 1 : cur_dly[c];
         if (tgt > m_cur[c]) m_cur[c]++;
         else if (tgt < m_cur[c]) m_cur[c]--;
      end
      m_wptr = (m_wptr + 1) & (MAX_DELAY-1);
      return e;
   endfunction

   task automatic drive_inputs();
      for (int c = 0; c < N_CH; c++) begin
         dl.in[c*W +: W]        = cur_in[c][W-1:0];
         dl.delay[c*AW +: AW]   = cur_dly[c][AW-1:0];
         dl.fb_gain[c*FBW +: FBW] = cur_fb[c][FBW-1:0];
      end
   endtask

   task automatic capture_out();
      for (int c = 0; c < N_CH; c++) got[c] = int'($signed(dl.out[c*W +: W]));
   endtask

   task automatic strobe_once();
      logic [N_CH*W-1:0] e;
      int n;
      bit seen;
      drive_inputs();
      exp_q.push_back(model_step());
      @(posedge clk); #1 dl.strobe = 1'b1;
      @(posedge clk); #1 dl.strobe = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         if (dl.out_valid) seen = 1'b1;
      end
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL out_valid_timeout: none within %0d cycles, required at %0d", n, LAT);
      end else begin
         if (n != LAT) begin
            errors++;
            $display("FAIL latency: out_valid after %0d cycles, required %0d", n, LAT);
         end
         checks++;
         if (dl.out !== e) begin
            errors++;
            $display("FAIL scoreboard_out: got %h, required %h", dl.out, e);
         end
         capture_out();
      end
   endtask

   task automatic count_clear(output int busy_cnt, output bit ov_seen);
      busy_cnt = 0;
      ov_seen  = 1'b0;
      for (int i = 0; i < CLR_CYCLES + 100; i++) begin
         @(negedge clk);
         if (dl.out_valid) ov_seen = 1'b1;
         if (!dl.busy) break;
         busy_cnt++;
         if (busy_cnt == 100) dl.strobe = 1'b1;
         if (busy_cnt == 101) dl.strobe = 1'b0;
      end
      dl.strobe = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dl.out_valid) ov_seen = 1'b1;
      end
   endtask

   task automatic do_reset();
      int bc;
      bit ov;
      dl.strobe = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      count_clear(bc, ov);
      checks++;
      if (bc != CLR_CYCLES) begin
         errors++;
         $display("FAIL reset_clear_len: busy for %0d cycles, required %0d", bc, CLR_CYCLES);
      end
   endtask

   task automatic test_reset();
      int bc;
      bit ov;
      dl.strobe = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (dl.out !== '0) begin errors++; $display("FAIL reset_out: got %h, required 0", dl.out); end
      if (dl.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", dl.out_valid); end
      if (dl.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", dl.busy); end
      @(posedge clk); #1 rst_n = 1'b1;
      model_reset();
      count_clear(bc, ov);
      checks += 2;
      if (bc != CLR_CYCLES) begin errors++; $display("FAIL clear_window: busy %0d cycles, required %0d", bc, CLR_CYCLES); end
      if (ov) begin errors++; $display("FAIL strobe_in_clear: out_valid seen, required none"); end
   endtask

   task automatic test_pure_delay();
      int d[N_CH] = '{1, 2, 5, 1023};
      do_reset();
      for (int c = 0; c < N_CH; c++) begin cur_dly[c] = d[c]; cur_fb[c] = 0; end
      for (int k = 0; k < 1040; k++) begin
         for (int c = 0; c < N_CH; c++) cur_in[c] = k;
         strobe_once();
         if (k >= 1035) begin
            for (int c = 0; c < N_CH; c++) begin
               checks++;
               if (got[c] != k - d[c]) begin
                  errors++;
                  $display("FAIL pure_delay ch%0d strobe %0d: got %0d, required %0d", c, k, got[c], k - d[c]);
               end
            end
         end
      end
   endtask

   task automatic test_slew();
      int eff, req;
      do_reset();
      for (int c = 0; c < N_CH; c++) begin cur_dly[c] = 1; cur_fb[c] = 0; end
      cur_dly[0] = 10;
      for (int k = 0; k < 30; k++) begin
         for (int c = 0; c < N_CH; c++) cur_in[c] = k;
         strobe_once();
      end
      cur_dly[0] = 20;
      for (int j = 0; j < 15; j++) begin
         for (int c = 0; c < N_CH; c++) cur_in[c] = 30 + j;
         strobe_once();
         eff = 30 + j - got[0];
         req = (10 + j > 20) ? 20 : 10 + j;
         checks++;
         if (eff != req) begin
            errors++;
            $display("FAIL slew step %0d: effective delay %0d, required %0d", j, eff, req);
         end
      end
   endtask

   task automatic test_feedback();
      int req;
      do_reset();
      for (int c = 0; c < N_CH; c++) begin cur_dly[c] = 4; cur_fb[c] = 0; cur_in[c] = 0; end
      cur_fb[0] = 128;
      for (int k = 0; k <= 12; k++) begin
         cur_in[0] = (k == 0) ? 16384 : 0;
         strobe_once();
         if (k == 4 || k == 8 || k == 12) begin
            req = 16384 >> (k/4 - 1);
            checks++;
            if (got[0] != req) begin
               errors++;
               $display("FAIL feedback strobe %0d: got %0d, required %0d", k, got[0], req);
            end
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int c = 0; c < N_CH; c++) begin cur_dly[c] = 1; cur_fb[c] = 255; end
      cur_in[0] = 32767; cur_in[1] = -32768; cur_in[2] = 1000; cur_in[3] = 0;
      for (int k = 0; k < 12; k++) begin
         strobe_once();
         if (k >= 2) begin
            checks += 2;
            if (got[0] != 32767) begin errors++; $display("FAIL sat_pos strobe %0d: got %0d, required 32767", k, got[0]); end
            if (got[1] != -32768) begin errors++; $display("FAIL sat_neg strobe %0d: got %0d, required -32768", k, got[1]); end
         end
      end
   endtask

   task automatic test_timing();
      int pulses, bc;
      bit ov;
      logic [N_CH*W-1:0] e, seen_out;
      do_reset();
      for (int c = 0; c < N_CH; c++) begin cur_dly[c] = 0; cur_fb[c] = 0; cur_in[c] = 111 + c; end
      strobe_once();
      for (int c = 0; c < N_CH; c++) cur_in[c] = 222 + c;
      strobe_once();
      for (int c = 0; c < N_CH; c++) begin
         checks++;
         if (got[c] != 111 + c) begin errors++; $display("FAIL delay_zero ch%0d: got %0d, required %0d", c, got[c], 111 + c); end
      end
      // A second strobe while servicing must neither start a pass nor disturb the first.
      for (int c = 0; c < N_CH; c++) cur_in[c] = 333 + c;
      drive_inputs();
      e = model_step();
      @(posedge clk); #1 dl.strobe = 1'b1;
      @(posedge clk); #1 dl.strobe = 1'b0;
      repeat (3) @(posedge clk);
      #1 dl.strobe = 1'b1;
      @(posedge clk); #1 dl.strobe = 1'b0;
      pulses = 0;
      seen_out = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dl.out_valid) begin pulses++; seen_out = dl.out; end
      end
      checks += 2;
      if (pulses != 1) begin errors++; $display("FAIL busy_strobe_ignored: %0d out_valid pulses, required 1", pulses); end
      if (seen_out !== e) begin errors++; $display("FAIL busy_strobe_out: got %h, required %h", seen_out, e); end
      for (int c = 0; c < N_CH; c++) cur_in[c] = 444 + c;
      strobe_once();
      // Reset while channel 0 is in its write cycle.
      @(posedge clk); #1 dl.strobe = 1'b1;
      @(posedge clk); #1 dl.strobe = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      checks += 3;
      if (dl.out !== '0) begin errors++; $display("FAIL midreset_out: got %h, required 0", dl.out); end
      if (dl.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b, required 1", dl.busy); end
      if (dl.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, required 0", dl.out_valid); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      count_clear(bc, ov);
      checks += 2;
      if (bc != CLR_CYCLES) begin errors++; $display("FAIL midreset_clear: busy %0d cycles, required %0d", bc, CLR_CYCLES); end
      if (ov) begin errors++; $display("FAIL midreset_ov: out_valid during clear, required none"); end
      for (int c = 0; c < N_CH; c++) cur_in[c] = 555 + c;
      strobe_once();
      strobe_once();
   endtask

   initial begin
      dl.strobe  = 1'b0;
      dl.in      = '0;
      dl.delay   = '0;
      dl.fb_gain = '0;
      for (int c = 0; c < N_CH; c++) begin cur_in[c] = 0; cur_dly[c] = 1; cur_fb[c] = 0; got[c] = 0; end
      model_reset();
      test_reset();
      test_pure_delay();
      test_slew();
      test_feedback();
      test_saturation();
      test_timing();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, required completion earlier");
      $fatal(1);
   end
endmodule
